// File: rtl/fp_hs_pkg.sv
// Shared types and constants for the stb/ack FPU handshake blocks and their benches.
package fp_hs_pkg;

  localparam int FP_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z,
    RESP
  } hs_state_e;

  // IEEE-754 single-precision constants for directed stimulus.
  localparam logic [31:0] FP_ONE     = 32'h3f80_0000;
  localparam logic [31:0] FP_HALF    = 32'h3f00_0000;
  localparam logic [31:0] FP_TWO     = 32'h4000_0000;
  localparam logic [31:0] FP_THREE   = 32'h4040_0000;
  localparam logic [31:0] FP_FOUR    = 32'h4080_0000;
  localparam logic [31:0] FP_NEG_TWO = 32'hc000_0000;
  localparam logic [31:0] FP_NEG_SIX = 32'hc0c0_0000;

endpackage

// File: rtl/fp_perf_cnt.sv
// Job and busy-cycle counters for fp_mul_initiator; both wrap modulo 2^CNT_W.
module fp_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             busy,
  input  logic             rsp_fire,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] busy_cycles
);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count    <= '0;
      busy_cycles <= '0;
    end else begin
      if (rsp_fire) op_count    <= op_count + CNT_W'(1);
      if (busy)     busy_cycles <= busy_cycles + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fp_mul_initiator.sv
// Initiator end of the stb/ack multiplier handshake: one job per request, A before B, result back.
// Optional performance counters are enabled by defining FP_MUL_INITIATOR_PERF_EN.
module fp_mul_initiator
  import fp_hs_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH
`ifdef FP_MUL_INITIATOR_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic [WIDTH-1:0] input_a,
  output logic             input_a_stb,
  input  logic             input_a_ack,
  output logic [WIDTH-1:0] input_b,
  output logic             input_b_stb,
  input  logic             input_b_ack,
  input  logic [WIDTH-1:0] output_z,
  input  logic             output_z_stb,
  output logic             output_z_ack
`ifdef FP_MUL_INITIATOR_PERF_EN
  ,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] busy_cycles
`endif
);

  hs_state_e        state_q, state_d;
  logic             req_ready_d, rsp_valid_d, input_a_stb_d, input_b_stb_d, output_z_ack_d;
  logic [WIDTH-1:0] rsp_z_d, input_a_d, input_b_d;

  // Every output is a register; the comb process only computes its next value.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    req_ready_d    = req_ready;
    rsp_valid_d    = rsp_valid;
    rsp_z_d        = rsp_z;
    input_a_d      = input_a;
    input_a_stb_d  = input_a_stb;
    input_b_d      = input_b;
    input_b_stb_d  = input_b_stb;
    output_z_ack_d = output_z_ack;

    case (state_q)
      IDLE: if (req_valid) begin
        input_a_d     = req_a;
        input_b_d     = req_b;
        req_ready_d   = 1'b0;
        input_a_stb_d = 1'b1;
        state_d       = SEND_A;
      end
      SEND_A: if (input_a_ack) begin
        input_a_stb_d = 1'b0;
        input_b_stb_d = 1'b1;
        state_d       = SEND_B;
      end
      SEND_B: if (input_b_ack) begin
        input_b_stb_d  = 1'b0;
        output_z_ack_d = 1'b1;
        state_d        = WAIT_Z;
      end
      WAIT_Z: if (output_z_stb) begin
        rsp_z_d        = output_z;
        output_z_ack_d = 1'b0;
        rsp_valid_d    = 1'b1;
        state_d        = RESP;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_z        <= '0;
      input_a      <= '0;
      input_a_stb  <= 1'b0;
      input_b      <= '0;
      input_b_stb  <= 1'b0;
      output_z_ack <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready    <= req_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_z        <= rsp_z_d;
      input_a      <= input_a_d;
      input_a_stb  <= input_a_stb_d;
      input_b      <= input_b_d;
      input_b_stb  <= input_b_stb_d;
      output_z_ack <= output_z_ack_d;
    end
  end

`ifdef FP_MUL_INITIATOR_PERF_EN
  fp_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .busy        (state_q != IDLE),
    .rsp_fire    (rsp_valid && rsp_ready),
    .op_count    (op_count),
    .busy_cycles (busy_cycles)
  );
`endif

endmodule

// File: doc/fp_mul_initiator.md
Name: fp_mul_initiator

Overview:
- Initiator (master) end of the stb/ack operand/result handshake used by the `multiplier` FPU.
- Accepts one operand pair per job from a systolic PE over a valid/ready request port.
- Delivers A, then B, to the FPU, collects output_z, and returns it on a valid/ready response port.
- One job in flight; it sits between each PE and its FPU instance.

Parameters:
- WIDTH, 32, operand/result width in bits (IEEE-754 single for the current FPU).
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  PE presents an operand pair
- req_ready  out  1  block can accept a job
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  PE accepts result
- rsp_z  out  WIDTH  product
- input_a  out  WIDTH  to FPU operand A
- input_a_stb  out  1  A strobe
- input_a_ack  in  1  FPU accepts A
- input_b  out  WIDTH  to FPU operand B
- input_b_stb  out  1  B strobe
- input_b_ack  in  1  FPU accepts B
- output_z  in  WIDTH  FPU result
- output_z_stb  in  1  FPU result strobe
- output_z_ack  out  1  block accepts result

Behaviour:
- Reset (synchronous, active-high; all outputs registered):
  - Reset takes effect on the clk edge with rst=1.
  - state=IDLE.
  - req_ready=1, rsp_valid=0, rsp_z=0.
  - input_a=0, input_b=0, all strobes=0, output_z_ack=0.
  - The FPU shares rst, so a reset mid-job aborts both ends cleanly; the partial job is dropped with no response.
- Transfer rule, all three channels: a beat transfers on the edge where stb && ack are both high. Once raised, a stb is held with stable data until that beat; it is deasserted on the following cycle.
- States:
  - IDLE: req_ready=1. On req_valid: latch req_a/req_b; req_ready<=0; input_a_stb<=1; go SEND_A.
  - SEND_A: on input_a_ack: input_a_stb<=0, input_b_stb<=1, go SEND_B. Strict A-before-B ordering; B is never strobed before A transfers.
  - SEND_B: on input_b_ack: input_b_stb<=0, output_z_ack<=1, go WAIT_Z.
  - WAIT_Z: output_z_ack held high. On output_z_stb: rsp_z<=output_z, output_z_ack<=0, rsp_valid<=1, go RESP.
  - RESP: hold rsp_valid and rsp_z stable. On rsp_ready: rsp_valid<=0, req_ready<=1, go IDLE.
- Latency with an ack-ready FPU:
  - req handshake at cycle 0.
  - input_a_stb high from cycle 1.
  - input_b_stb high the cycle after the A transfer.
  - rsp_valid the cycle after the Z transfer.
- Backpressure: while rsp_ready=0 no new job is accepted (req_ready=0) and output_z_ack stays 0 after capture.
- No back-to-back overlap: the minimum spacing between req handshakes is one IDLE cycle.
- Data is passed through bit-exact; the block does no arithmetic.
- Unexpected input_*_ack or output_z_stb outside its state is ignored.

Optional Feature:
- Macro FP_MUL_INITIATOR_PERF_EN.
- With the macro, two extra outputs exist:
  - op_count [CNT_W]: increments on each rsp handshake.
  - busy_cycles [CNT_W]: increments every cycle state!=IDLE.
  - Both clear on rst and wrap modulo 2^CNT_W.
- Without the macro, these ports and their logic are absent.

Decomposition:
- Shared package fp_hs_pkg holds:
  - the FP_WIDTH constant (32);
  - the state typedef {IDLE, SEND_A, SEND_B, WAIT_Z, RESP};
  - FP constants used by benches (1.0=0x3f800000 etc.).
- Natural sub-module: fp_perf_cnt, holding the two counters. It is instantiated only under FP_MUL_INITIATOR_PERF_EN.

Test Plan:
- Basic job against the real multiplier:
  - Stimulus: req_a=0x40800000 (4.0), req_b=0x3f000000 (0.5), rsp_ready=1.
  - Required: rsp_z=0x40000000 (2.0).
  - Required: A strobed strictly before B; each stb high until its ack beat, then dropped the next cycle.
- Sign case: 0x40400000 × 0xc0000000 -> rsp_z=0xc0c00000 (-6.0).
- Slow responder (behavioural FPU with input_a_ack delayed 3 cycles):
  - input_a_stb stays high and input_a stays stable for all 3 cycles.
  - input_b_stb stays 0 until the cycle after the A transfer.
- Response backpressure, rsp_ready=0 for 5 cycles after rsp_valid:
  - rsp_valid and rsp_z are held.
  - req_ready=0 and output_z_ack=0 throughout.
  - A second req_valid is not accepted until the cycle after the rsp handshake.
- Reset in WAIT_Z: assert rst for 1 cycle.
  - The next cycle shows all outputs at reset values and req_ready=1.
  - A new job 4.0×0.5 then returns 0x40000000.
- With FP_MUL_INITIATOR_PERF_EN, run 3 back-to-back jobs:
  - op_count=3 at the end.
  - busy_cycles equals the summed non-IDLE cycles counted by the bench.
